// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch
// Description : Sequential instruction prefetcher with a small {pc,data} FIFO,
//               branch-redirect flush and halt, feeding the decode sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch #(
    parameter int               DEPTH    = 4,
    parameter int               ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_gnt,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic                    instr_valid,
    output logic [31:0]             instr_data,
    output logic [ADDR_W-1:0]       instr_pc,
    input  logic                    instr_ready,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    input  logic                    halt,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_fpc;
    logic [ADDR_W-1:0]  r_tag;
    logic               r_inflight;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;
    logic [31:0]        r_data [DEPTH];
    logic [ADDR_W-1:0]  r_pc   [DEPTH];

    logic [c_PTR_W:0]   w_occupied;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    // The in-flight word already owns a slot, so requests stop one early.
    assign w_occupied  = r_count + {{c_PTR_W{1'b0}}, r_inflight};
    assign mem_req     = !rst && !halt && !redirect_valid && (w_occupied < c_DEPTH);
    assign mem_addr    = r_fpc;
    assign w_accept    = mem_req && mem_gnt;
    assign w_push      = mem_rvalid && r_inflight && !redirect_valid && !rst;
    assign w_pop       = instr_valid && instr_ready;

    assign instr_valid = (r_count != '0);
    assign instr_data  = instr_valid ? r_data[r_rptr] : '0;
    assign instr_pc    = instr_valid ? r_pc[r_rptr]   : '0;
    assign fifo_count  = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc      <= RESET_PC;
            r_tag      <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fpc      <= redirect_pc;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_inflight <= 1'b1;
                r_tag      <= r_fpc;
                r_fpc      <= r_fpc + ADDR_W'(1);
            end else if (w_push) begin
                r_inflight <= 1'b0;
            end
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= mem_rdata;
            r_pc[r_wptr]   <= r_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            assert (!(w_push && !w_pop && (r_count == c_DEPTH)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_prefetch
// Description : Randomized scoreboard bench for instr_prefetch with a queue
//               based reference model and a fixed-latency memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       data;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_gnt = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              instr_valid;
    logic [31:0]       instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halt = 1'b0;
    logic [2:0]        fifo_count;

    instr_prefetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(12'd2)) dut (
        .clk(clk), .rst(rst), .mem_gnt(mem_gnt), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    ent_t exp_q[$];

    // Reference model: fetch pointer, one outstanding read, expected queue.
    logic [ADDR_W-1:0] m_fpc = 12'd2;
    logic [ADDR_W-1:0] m_tag = '0;
    bit                m_inflight = 0;
    bit                pend = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    bit                synced = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit g, input bit h,
                        input bit rv, input logic [ADDR_W-1:0] rpc);
        bit m_req;
        bit acc;
        bit resp;
        @(negedge clk);
        rst = r; instr_ready = rdy; mem_gnt = g; halt = h;
        redirect_valid = rv; redirect_pc = rpc;
        mem_rvalid = pend ? 1'b1 : ($urandom_range(0, 7) == 0);
        mem_rdata  = pend ? 32'h1000_0000 + {20'h0, pend_addr} : $urandom;
        #1;
        m_req = !r && !h && !rv && ((exp_q.size() + int'(m_inflight)) < DEPTH);
        check("mem_req", {31'h0, mem_req}, {31'h0, m_req});
        if (m_req) check("mem_addr", {20'h0, mem_addr}, {20'h0, m_fpc});
        if (synced) begin
            check("fifo_count", {29'h0, fifo_count}, exp_q.size());
            check("instr_valid", {31'h0, instr_valid}, {31'h0, exp_q.size() != 0});
            if (exp_q.size() == 0) begin
                check("idle_pc", {20'h0, instr_pc}, 32'h0);
                check("idle_data", instr_data, 32'h0);
            end
        end
        #2;
        acc  = m_req && g;
        resp = mem_rvalid && m_inflight;
        pend = acc;
        if (acc) pend_addr = m_fpc;
        if (r) begin
            m_fpc = 12'd2; m_inflight = 0; exp_q.delete(); synced = 1;
        end else if (rv) begin
            m_fpc = rpc; m_inflight = 0; exp_q.delete();
        end else begin
            if (resp) exp_q.push_back('{m_tag, 32'h1000_0000 + {20'h0, m_tag}});
            if (acc) begin
                m_inflight = 1; m_tag = m_fpc; m_fpc = m_fpc + 12'd1;
            end else if (resp) begin
                m_inflight = 0;
            end
        end
    endtask

    task automatic run(input int n, input bit r, input bit rdy, input bit g,
                       input bit h, input bit rv, input logic [ADDR_W-1:0] rpc);
        for (int i = 0; i < n; i++) step(r, rdy, g, h, rv, rpc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over an instruction.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !redirect_valid && instr_valid === 1'b1 && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", {31'h0, instr_valid}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", {20'h0, instr_pc}, {20'h0, e.pc});
                    check("instr_data", instr_data, e.data);
                end
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] tgt;
        run(3, 1, 1, 1, 0, 0, '0);
        run(10, 0, 1, 1, 0, 0, '0);
        run(8, 0, 0, 1, 0, 0, '0);
        run(1, 0, 1, 1, 0, 0, '0);
        run(3, 0, 0, 1, 0, 0, '0);
        run(1, 0, 1, 1, 0, 1, 12'h004);
        run(6, 0, 1, 1, 0, 0, '0);
        run(3, 0, 1, 0, 0, 0, '0);
        run(4, 0, 1, 1, 0, 0, '0);
        run(5, 0, 1, 1, 1, 0, '0);
        run(4, 0, 1, 1, 0, 0, '0);
        run(1, 0, 1, 1, 0, 1, 12'hFFF);
        run(6, 0, 1, 1, 0, 0, '0);
        run(1, 1, 1, 1, 0, 0, '0);
        run(6, 0, 1, 1, 0, 0, '0);
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       tgt = 12'hFFF;
                1:       tgt = 12'hFFE;
                2:       tgt = 12'h004;
                default: tgt = 12'($urandom);
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 24) == 0, tgt);
        end
        run(12, 0, 1, 1, 0, 0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
